regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-back scheduler for the single register-file write port of the MIPS datapath.
- Arbitrates between two result producers:
  - Port A: single-cycle ALU path.
  - Port B: multi-cycle load/multiply path.
- Resolves each winner's destination register (rt vs rd vs $ra) through a mux5bit instance, then issues one registered write per cycle.
- Also provides write-back-to-decode forwarding hit flags.

Parameters:
- DATA_W, 32, write-data width.
- STARVE_MAX, 3, maximum consecutive cycles port B may be denied while valid; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  port A has a result
- a_ready  output  1  port A result accepted this cycle
- a_rt  input  5  port A rt field
- a_rd  input  5  port A rd field
- a_regdst  input  1  port A destination select: 0 = rt, 1 = rd
- a_link  input  1  port A writes $31 (jal); overrides a_regdst
- a_data  input  DATA_W  port A result
- b_valid  input  1  port B has a result
- b_ready  output  1  port B result accepted this cycle
- b_rt  input  5  port B rt field
- b_rd  input  5  port B rd field
- b_regdst  input  1  port B destination select: 0 = rt, 1 = rd
- b_data  input  DATA_W  port B result
- rs_addr  input  5  decode-stage rs read address
- rt_addr  input  5  decode-stage rt read address
- rf_we  output  1  register-file write enable
- rf_wa  output  5  register-file write address
- rf_wd  output  DATA_W  register-file write data
- fwd_rs  output  1  rs_addr hits the write in flight
- fwd_rt  output  1  rt_addr hits the write in flight

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_wa=0, rf_wd=0, starve_cnt=0.
  - a_ready, b_ready, fwd_rs and fwd_rt are forced to 0 while rst_n is low.
- Transfer rule: a transfer occurs on a rising edge where valid&ready are both 1.
- ready generation:
  - ready is combinational from valid and starve_cnt.
  - Producers must not make valid depend on ready.
- Grant rule, evaluated every cycle:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant B if starve_cnt == STARVE_MAX, else grant A.
  - At most one of a_ready and b_ready is high in any cycle.
- starve_cnt, updated on each rising edge:
  - Increments when b_valid=1 and B is not granted.
  - Clears when B is granted or b_valid=0.
  - Saturates at STARVE_MAX.
  - Width: 4 bits.
- Destination resolution, combinational, for the granted port:
  - Each port's rt/rd pair passes through its own mux5bit instance, with inputA=rt, inputB=rd, select=regdst.
  - a_link=1 forces 5'd31 regardless of a_regdst.
- Output stage, registered, latency 1:
  - A grant at edge N drives rf_we=1, rf_wa=resolved address and rf_wd=granted data during cycle N+1, for exactly one cycle.
  - rf_we=0 in any cycle that follows an edge with no grant; rf_wa and rf_wd hold their previous values.
- $zero rule:
  - If the resolved address is 0, the handshake still completes, but rf_we stays 0.
  - rf_wa and rf_wd still update.
- Forwarding:
  - fwd_rs = rf_we & (rs_addr == rf_wa) & (rs_addr != 0); purely combinational.
  - fwd_rt = rf_we & (rt_addr == rf_wa) & (rt_addr != 0); purely combinational.
- Back-to-back operation: one write per cycle sustained; no bubble required between grants.
- Reset mid-operation: a write registered before reset assertion is discarded; no rf_we pulse occurs after rst_n rises until a new grant.
- Data and address inputs are sampled only at a transfer edge; values in non-transfer cycles are don't-care.

Test Plan:
- A only, a_rt=5, a_rd=9, a_regdst=1, a_data=0x1234 -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=9, rf_wd=0x1234; following cycle rf_we=0.
- A jal, a_link=1, a_regdst=0, a_rt=4 -> rf_wa=31.
- A and B both valid continuously, STARVE_MAX=3:
  - Grant sequence is A,A,A,B,A,A,A,B.
  - b_ready is high exactly every 4th cycle.
  - No cycle has both ready signals high.
- B only, b_regdst=0, b_rt=0, b_data=0xFFFF -> b_ready=1; next cycle rf_we=0, rf_wa=0.
- Write in flight rf_wa=7, rf_we=1, with rs_addr=7, rt_addr=0 -> fwd_rs=1, fwd_rt=0; same case with rt_addr=7 -> fwd_rt=1.
- Assert rst_n=0 mid-cycle right after a grant edge -> rf_we drops to 0 immediately without waiting for clk; after release with no valid, rf_we stays 0 and starve_cnt=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the single register-file write port: arbitrates the
// ALU path (A) against the load/multiply path (B) and registers one write per cycle.

module mux5bit (
  input  logic [4:0] input_a,
  input  logic [4:0] input_b,
  input  logic       select,
  output logic [4:0] out_c
);
  assign out_c = select ? input_b : input_a;
endmodule

module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_rt,
  input  logic [4:0]        a_rd,
  input  logic              a_regdst,
  input  logic              a_link,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_rt,
  input  logic [4:0]        b_rd,
  input  logic              b_regdst,
  input  logic [DATA_W-1:0] b_data,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              fwd_rs,
  output logic              fwd_rt
);
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] LINK_REG = AW'(31);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]     starve_cnt;
  logic [CW-1:0]     starve_nxt_c;
  logic              grant_a_c;
  logic              grant_b_c;
  logic [AW-1:0]     a_mux_c;
  logic [AW-1:0]     b_mux_c;
  logic [AW-1:0]     a_wa_c;
  logic [AW-1:0]     wa_sel_c;
  logic [DATA_W-1:0] wd_sel_c;

  mux5bit u_mux_a (
    .input_a (a_rt),
    .input_b (a_rd),
    .select  (a_regdst),
    .out_c   (a_mux_c)
  );

  mux5bit u_mux_b (
    .input_a (b_rt),
    .input_b (b_rd),
    .select  (b_regdst),
    .out_c   (b_mux_c)
  );

  // A wins by default; B wins alone or once it has been starved STARVE_MAX cycles
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (a_valid && b_valid) begin
      if (starve_cnt == STARVE_LIM) grant_b_c = 1'b1;
      else                          grant_a_c = 1'b1;
    end else if (a_valid) begin
      grant_a_c = 1'b1;
    end else if (b_valid) begin
      grant_b_c = 1'b1;
    end
  end

  assign a_ready = grant_a_c & rst_n;
  assign b_ready = grant_b_c & rst_n;

  always_comb begin
    starve_nxt_c = '0;
    if (b_valid && !grant_b_c) begin
      starve_nxt_c = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + CW'(1);
    end
  end

  always_comb begin
    a_wa_c   = a_link ? LINK_REG : a_mux_c;
    wa_sel_c = grant_b_c ? b_mux_c : a_wa_c;
    wd_sel_c = grant_b_c ? b_data : a_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt_c;
  end

  // Writes to $zero still complete the handshake and update wa/wd, but never assert we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= (grant_a_c | grant_b_c) && (wa_sel_c != '0);
      if (grant_a_c | grant_b_c) begin
        rf_wa <= wa_sel_c;
        rf_wd <= wd_sel_c;
      end
    end
  end

  assign fwd_rs = rst_n & rf_we & (rs_addr == rf_wa) & (rs_addr != '0);
  assign fwd_rt = rst_n & rf_we & (rt_addr == rf_wa) & (rt_addr != '0);

endmodule
